// File: rtl/xdma_write_req_arbiter.sv
// xdma_write_req_arbiter
// Round-robin arbiter that shares one write-request burst reshaper between
// several xDMA request frontends. A granted descriptor is captured and held
// for the whole reshaper job. The reshaper gets a one-cycle start pulse, and
// the arbiter does not grant again until the reshaper reports completion.

package xdma_write_req_arbiter_pkg;

  typedef struct packed {
    logic [7:0]  dma_id;
    logic [1:0]  dma_type;
    logic [31:0] remote_addr;
    logic [15:0] dma_length;
    logic        ready_to_transfer;
  } xdma_req_desc_t;

endpackage

module xdma_write_req_arbiter #(
  parameter int unsigned NumReq        = 3,
  parameter type         xdma_req_desc_t = xdma_write_req_arbiter_pkg::xdma_req_desc_t,
  parameter type         xdma_req_idx_t  = logic [$clog2(NumReq)-1:0],
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  xdma_req_desc_t        req_desc_i [NumReq],
  input  logic [NumReq-1:0]     req_valid_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic [NumReq-1:0]     req_done_o,
  output xdma_req_desc_t        write_req_desc_o,
  output xdma_req_idx_t         write_req_idx_o,
  output logic                  write_req_desc_valid_o,
  input  logic                  write_req_done_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  // The watchdog counter saturates at TimeoutCycles, so it needs one extra code.
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_r, state_s;
  xdma_req_idx_t     rr_r, rr_next_s;
  xdma_req_idx_t     idx_r, grant_s;
  xdma_req_desc_t    desc_r, grant_desc_s;
  logic [NumReq-1:0] pick_s, ready_s, done_vec_r;
  logic              found_s, accept_s;
  logic              desc_valid_r, busy_r, timeout_r;
  logic [CntW-1:0]   cnt_r;

  // One-hot decode of a requester index.
  function automatic logic [NumReq-1:0] onehot(input xdma_req_idx_t idx);
    logic [NumReq-1:0] vec;
    for (int i = 0; i < int'(NumReq); i++) begin
      vec[i] = (int'(idx) == i);
    end
    return vec;
  endfunction

  // Find the first valid requester at or after the rr pointer, wrapping.
  always_comb begin
    int cand_v;
    cand_v       = 0;
    found_s      = 1'b0;
    grant_s      = '0;
    grant_desc_s = '0;
    pick_s       = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand_v = (int'(rr_r) + i) % int'(NumReq);
      if (!found_s && req_valid_i[cand_v]) begin
        found_s         = 1'b1;
        grant_s         = xdma_req_idx_t'(cand_v);
        grant_desc_s    = req_desc_i[cand_v];
        pick_s[cand_v]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    rr_next_s = xdma_req_idx_t'((int'(grant_s) + 1) % int'(NumReq));
  end

  // Next-state logic and the combinational accept handshake.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    ready_s  = '0;
    case (state_r)
      ST_IDLE: begin
        // Gated with rst_ni so no accept is shown while reset is held.
        if (found_s && rst_ni) begin
          accept_s = 1'b1;
          ready_s  = pick_s;
          // Zero-length jobs never reach the reshaper.
          if (grant_desc_s.dma_length == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (write_req_done_i) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the winner's descriptor and index, and advance the rr pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desc_r <= '0;
      idx_r  <= '0;
      rr_r   <= '0;
    end else if (accept_s) begin
      desc_r <= grant_desc_s;
      idx_r  <= grant_s;
      rr_r   <= rr_next_s;
    end else begin
      desc_r <= desc_r;
      idx_r  <= idx_r;
      rr_r   <= rr_r;
    end
  end

  // Registered start pulse, completion pulse and busy flag, aligned to the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      desc_valid_r <= 1'b0;
      done_vec_r   <= '0;
      busy_r       <= 1'b0;
    end else begin
      desc_valid_r <= (state_s == ST_ISSUE);
      busy_r       <= (state_s != ST_IDLE);
      if (state_s == ST_DONE) begin
        done_vec_r <= onehot(accept_s ? grant_s : idx_r);
      end else begin
        done_vec_r <= '0;
      end
    end
  end

  // Watchdog: counts cycles spent in WAIT; the flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= '0;
      timeout_r <= 1'b0;
    end else if (state_r == ST_WAIT) begin
      if (32'(cnt_r) < TimeoutCycles) begin
        cnt_r <= cnt_r + CntW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if ((TimeoutCycles != 32'd0) && ((32'(cnt_r) + 32'd1) == TimeoutCycles)) begin
        timeout_r <= 1'b1;
      end else begin
        timeout_r <= timeout_r;
      end
    end else begin
      cnt_r     <= '0;
      timeout_r <= timeout_r;
    end
  end

  assign req_ready_o            = ready_s;
  assign req_done_o             = done_vec_r;
  assign write_req_desc_o       = desc_r;
  assign write_req_idx_o        = idx_r;
  assign write_req_desc_valid_o = desc_valid_r;
  assign busy_o                 = busy_r;
  assign timeout_o              = timeout_r;

endmodule

// File: tb/tb_xdma_write_req_arbiter.sv
// Testbench for xdma_write_req_arbiter: directed stimulus, a job-level
// timestamp model compared every cycle, plus literal per-scenario checks.

module tb_xdma_write_req_arbiter;
  import xdma_write_req_arbiter_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_ni;
  xdma_req_desc_t req_desc [N];
  logic [N-1:0]   req_valid, req_ready, req_done;
  xdma_req_desc_t wr_desc;
  logic [1:0]     wr_idx;
  logic           wr_valid, wr_done, busy, timeout;

  int n_cmp  = 0;
  int n_fail = 0;
  int tb_cyc = 0;

  xdma_write_req_arbiter #(
    .NumReq        (N),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_ni),
    .req_desc_i             (req_desc),
    .req_valid_i            (req_valid),
    .req_ready_o            (req_ready),
    .req_done_o             (req_done),
    .write_req_desc_o       (wr_desc),
    .write_req_idx_o        (wr_idx),
    .write_req_desc_valid_o (wr_valid),
    .write_req_done_i       (wr_done),
    .busy_o                 (busy),
    .timeout_o              (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, tb_cyc, act, exp);
    end
  endtask

  function automatic xdma_req_desc_t mk(input logic [7:0] id, input logic [31:0] addr,
                                        input logic [15:0] len);
    xdma_req_desc_t d;
    d.dma_id            = id;
    d.dma_type          = 2'd1;
    d.remote_addr       = addr;
    d.dma_length        = len;
    d.ready_to_transfer = 1'b1;
    return d;
  endfunction

  // ---------------- job-level model ----------------
  // A job is described by its accept cycle, its winner and the cycle done_i
  // arrived; every output is derived from those timestamps.
  bit             m_busy = 1'b0;
  bit             m_zero = 1'b0;
  bit             m_tmo  = 1'b0;
  int             m_ptr  = 0;
  int             m_acc  = 0;
  int             m_g    = 0;
  int             m_done_cyc = -1;
  xdma_req_desc_t m_desc = '0;
  logic [1:0]     m_idx  = 2'd0;

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_done;
    logic         e_valid;
    int           win, p, w;
    if (!rst_ni) begin
      m_busy = 1'b0; m_zero = 1'b0; m_tmo = 1'b0; m_ptr = 0;
      m_done_cyc = -1; m_desc = '0; m_idx = 2'd0;
      check("rst_ready", req_ready, 64'd0);
      check("rst_done", req_done, 64'd0);
      check("rst_valid", wr_valid, 64'd0);
      check("rst_busy", busy, 64'd0);
      check("rst_timeout", timeout, 64'd0);
      check("rst_idx", wr_idx, 64'd0);
      check("rst_desc", wr_desc, 64'd0);
    end else begin
      win = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          p = (m_ptr + i) % N;
          if (win < 0 && req_valid[p]) win = p;
        end
      end
      e_ready = (win >= 0) ? (3'b001 << win) : 3'b000;
      e_valid = m_busy && !m_zero && (tb_cyc == m_acc + 1);
      e_done  = 3'b000;
      if (m_busy && ((m_zero && tb_cyc == m_acc + 1) ||
                     (!m_zero && m_done_cyc >= 0 && tb_cyc == m_done_cyc + 1)))
        e_done = 3'b001 << m_g;
      check("mdl_ready", req_ready, e_ready);
      check("mdl_req_done", req_done, e_done);
      check("mdl_valid_o", wr_valid, e_valid);
      check("mdl_busy", busy, m_busy);
      check("mdl_timeout", timeout, m_tmo);
      check("mdl_idx", wr_idx, m_idx);
      check("mdl_desc", wr_desc, m_desc);
      // advance to the next cycle
      if (!m_busy) begin
        if (win >= 0) begin
          m_busy = 1'b1; m_acc = tb_cyc; m_g = win; m_done_cyc = -1;
          m_zero = (req_desc[win].dma_length == 16'd0);
          m_ptr  = (win + 1) % N;
          m_desc = req_desc[win];
          m_idx  = 2'(win);
        end
      end else if (e_done != 3'b000) begin
        m_busy = 1'b0;
      end else if (!m_zero && m_done_cyc < 0 && tb_cyc >= m_acc + 2) begin
        w = tb_cyc - (m_acc + 2);
        if (w + 1 == TMO) m_tmo = 1'b1;
        if (wr_done) m_done_cyc = tb_cyc;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int order [4];
  int done_cyc, k, n;

  initial begin
    rst_ni    = 1'b0;
    req_valid = 3'b000;
    wr_done   = 1'b0;
    for (int i = 0; i < N; i++) req_desc[i] = mk(8'(i), 32'h0, 16'd1);
    repeat (3) tick();
    rst_ni = 1'b1;
    #3;
    check("reset_busy", busy, 64'd0);
    check("reset_idx", wr_idx, 64'd0);

    // 1: single request on port 1
    tick();
    req_desc[1] = mk(8'h11, 32'h1000, 16'd5);
    req_valid   = 3'b010;
    #3 check("t1_ready", req_ready, 64'b010);
    tick();
    req_valid = 3'b000;
    #3;
    check("t1_valid_o", wr_valid, 64'd1);
    check("t1_idx", wr_idx, 64'd1);
    check("t1_len", wr_desc.dma_length, 64'd5);
    check("t1_addr", wr_desc.remote_addr, 64'h1000);

    // 2: done at T+10
    repeat (9) tick();
    wr_done = 1'b1;
    #3 check("t2_done_early", req_done, 64'd0);
    tick();
    wr_done = 1'b0;
    #3 check("t2_req_done", req_done, 64'b010);
    tick();
    #3 check("t2_busy", busy, 64'd0);

    // 3: all ports valid continuously after a fresh reset
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni    = 1'b1;
    req_valid = 3'b111;
    #3;
    done_cyc = 0;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (req_ready == 3'b000 && k < 20) begin
        tick(); #3; k++;
      end
      check("t3_accept_seen", (req_ready != 3'b000), 64'd1);
      order[j] = req_ready[0] ? 0 : (req_ready[1] ? 1 : (req_ready[2] ? 2 : -1));
      if (j > 0) check("t3_gap", tb_cyc - done_cyc, 64'd2);
      tick();
      if (j == 3) req_valid = 3'b000;
      tick();
      wr_done  = 1'b1;
      done_cyc = tb_cyc;
      tick();
      wr_done = 1'b0;
      #3;
    end
    check("t3_order0", order[0], 64'd0);
    check("t3_order1", order[1], 64'd1);
    check("t3_order2", order[2], 64'd2);
    check("t3_order3", order[3], 64'd0);

    // 4: zero-length job on port 2
    tick();
    req_desc[2] = mk(8'h22, 32'h0, 16'd0);
    req_valid   = 3'b100;
    #3 check("t4_ready", req_ready, 64'b100);
    tick();
    req_valid = 3'b000;
    #3;
    check("t4_req_done", req_done, 64'b100);
    check("t4_valid_o", wr_valid, 64'd0);
    tick();
    #3 check("t4_busy", busy, 64'd0);

    // 5: watchdog
    req_desc[0] = mk(8'h50, 32'h2000, 16'd7);
    req_valid   = 3'b001;
    #3 check("t5_ready", req_ready, 64'b001);
    n = 0;
    do begin
      tick();
      req_valid = 3'b000;
      #3;
      n++;
    end while (!timeout && n < 40);
    check("t5_wait_cycles", n - 2, 64'd16);
    check("t5_busy", busy, 64'd1);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #3;
    check("t5_req_done", req_done, 64'b001);
    check("t5_timeout_sticky", timeout, 64'd1);
    tick();
    #3;
    check("t5_busy_end", busy, 64'd0);
    check("t5_timeout_hold", timeout, 64'd1);

    // 6: reset during WAIT
    req_desc[1] = mk(8'h61, 32'h3000, 16'd3);
    req_valid   = 3'b010;
    #3 check("t6_ready", req_ready, 64'b010);
    tick();
    req_valid = 3'b000;
    tick();
    tick();
    req_valid = 3'b101;
    rst_ni    = 1'b0;
    #1;
    check("t6_busy", busy, 64'd0);
    check("t6_timeout", timeout, 64'd0);
    check("t6_valid_o", wr_valid, 64'd0);
    check("t6_idx", wr_idx, 64'd0);
    check("t6_desc", wr_desc, 64'd0);
    check("t6_ready_rst", req_ready, 64'd0);
    tick();
    rst_ni = 1'b1;
    #3 check("t6_regrant", req_ready, 64'b001);
    tick();
    req_valid = 3'b000;
    tick();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    #3 check("t6_req_done", req_done, 64'b001);
    tick();
    #3 check("t6_busy_end", busy, 64'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end

endmodule
